// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : wb_pkg                                                     |
// | Description : Shared types and constants for the write-back stage:       |
// |               FSM state encoding, load opcode, default datapath widths   |
// |               and the hard-wired zero register index.                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      COMMIT   = 2'd2
   } wb_state_t;

   localparam logic [5:0] OPC_LW     = 6'b100011;
   localparam int         DEF_DATA_W = 32;
   localparam int         DEF_ADDR_W = 5;
   localparam int         REG_ZERO   = 0;

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : wb_stage_if                                                |
// | Description : EX/DM -> WB hand-off bundle plus the data-memory read      |
// |               return and the stall back to the upstream stages.          |
// |   master : drives ex_dm_* and dm_rdata/dm_rvalid, receives wb_stall      |
// |   slave  : the write-back stage                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface wb_stage_if
   import wb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              ex_dm_valid;
   logic [31:0]       ex_dm_inst;
   logic [DATA_W-1:0] ex_dm_alu_result;
   logic [ADDR_W-1:0] ex_dm_wb_addr;
   logic              ex_dm_w_enable;
   logic              ex_dm_wb_mux_ctrl;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_rvalid;
   logic              wb_stall;

   modport master (
      output ex_dm_valid, ex_dm_inst, ex_dm_alu_result, ex_dm_wb_addr,
             ex_dm_w_enable, ex_dm_wb_mux_ctrl, dm_rdata, dm_rvalid,
      input  wb_stall
   );

   modport slave (
      input  ex_dm_valid, ex_dm_inst, ex_dm_alu_result, ex_dm_wb_addr,
             ex_dm_w_enable, ex_dm_wb_mux_ctrl, dm_rdata, dm_rvalid,
      output wb_stall
   );
endinterface
`default_nettype wire

// File: rtl/wb_stage_mem_wb_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_wb_reg                                                 |
// | Description : MEM/WB pipeline register. When i_en is high the valid bit  |
// |               follows i_valid and the payload is loaded for valid ops.   |
// |               i_clear drops the held op (valid only), overriding i_en.   |
// |   clk, rst_n        : clock, async active-low reset                      |
// |   i_en, i_clear     : capture enable, discard held op                    |
// |   i_* / o_*         : valid, inst, alu_result, wb_addr, w_enable, mux    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_wb_reg
   import wb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              i_en,
   input  wire logic              i_clear,
   input  wire logic              i_valid,
   input  wire logic [31:0]       i_inst,
   input  wire logic [DATA_W-1:0] i_alu_result,
   input  wire logic [ADDR_W-1:0] i_wb_addr,
   input  wire logic              i_w_enable,
   input  wire logic              i_wb_mux_ctrl,
   output logic                   o_valid,
   output logic [31:0]            o_inst,
   output logic [DATA_W-1:0]      o_alu_result,
   output logic [ADDR_W-1:0]      o_wb_addr,
   output logic                   o_w_enable,
   output logic                   o_wb_mux_ctrl
);
   logic              r_valid;
   logic [31:0]       r_inst;
   logic [DATA_W-1:0] r_alu_result;
   logic [ADDR_W-1:0] r_wb_addr;
   logic              r_w_enable;
   logic              r_wb_mux_ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid       <= 1'b0;
         r_inst        <= '0;
         r_alu_result  <= '0;
         r_wb_addr     <= '0;
         r_w_enable    <= 1'b0;
         r_wb_mux_ctrl <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_en) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_inst        <= i_inst;
            r_alu_result  <= i_alu_result;
            r_wb_addr     <= i_wb_addr;
            r_w_enable    <= i_w_enable;
            r_wb_mux_ctrl <= i_wb_mux_ctrl;
         end
      end
   end

   assign o_valid       = r_valid;
   assign o_inst        = r_inst;
   assign o_alu_result  = r_alu_result;
   assign o_wb_addr     = r_wb_addr;
   assign o_w_enable    = r_w_enable;
   assign o_wb_mux_ctrl = r_wb_mux_ctrl;
endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_stage                                                   |
// | Description : Write-back end of the 5-stage pipeline. Holds MEM/WB,      |
// |               selects ALU result or load data, drives the register-file  |
// |               write port, stalls upstream during multi-cycle loads and   |
// |               exports forwarding data and a retire counter.              |
// |   clk, rst_n      : clock, async active-low reset                        |
// |   bus (slave)     : EX/DM op, data-memory return, wb_stall               |
// |   wd_addr/wd_data/rd_w_enable : register-file write port                 |
// |   dm_wb_inst      : held instruction (0 when empty)                      |
// |   fwd_wb_*        : forwarding source                                    |
// |   retired_count   : committed-op counter (wraps)                         |
// |   err_mem_timeout : sticky load-timeout flag                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module wb_stage
   import wb_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   wb_stage_if.slave     bus,
   output logic [ADDR_W-1:0] wd_addr,
   output logic [DATA_W-1:0] wd_data,
   output logic              rd_w_enable,
   output logic [31:0]       dm_wb_inst,
   output logic              fwd_wb_valid,
   output logic [ADDR_W-1:0] fwd_wb_addr,
   output logic [DATA_W-1:0] fwd_wb_data,
   output logic [CNT_W-1:0]  retired_count,
   output logic              err_mem_timeout
);
   localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

   wb_state_t         r_state;
   wb_state_t         w_state_nxt;
   logic              w_stall;
   logic              w_commit;
   logic              w_timeout;
   logic              w_slot_open;
   logic              w_load_latch;
   logic              w_addr_nz;
   logic [DATA_W-1:0] w_wd_data;

   logic              r_wb_valid;
   logic [31:0]       r_inst;
   logic [DATA_W-1:0] r_alu_result;
   logic [ADDR_W-1:0] r_wb_addr;
   logic              r_w_enable;
   logic              r_wb_mux_ctrl;
   logic [DATA_W-1:0] r_load_data;
   logic [c_WAIT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0]  r_retired;
   logic              r_err;

   // MEM/WB accepts a new op in every state except WAIT_MEM, so COMMIT
   // can overlap the next capture.
   assign w_slot_open = (r_state != WAIT_MEM);

   // Last WAIT_MEM cycle without a read return.
   assign w_timeout = (r_state == WAIT_MEM) && !bus.dm_rvalid &&
                      (r_wait_cnt == c_WAIT_W'(MEM_TIMEOUT - 1));

   mem_wb_reg #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem_wb_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_en          (w_slot_open),
      .i_clear       (w_timeout),
      .i_valid       (bus.ex_dm_valid),
      .i_inst        (bus.ex_dm_inst),
      .i_alu_result  (bus.ex_dm_alu_result),
      .i_wb_addr     (bus.ex_dm_wb_addr),
      .i_w_enable    (bus.ex_dm_w_enable),
      .i_wb_mux_ctrl (bus.ex_dm_wb_mux_ctrl),
      .o_valid       (r_wb_valid),
      .o_inst        (r_inst),
      .o_alu_result  (r_alu_result),
      .o_wb_addr     (r_wb_addr),
      .o_w_enable    (r_w_enable),
      .o_wb_mux_ctrl (r_wb_mux_ctrl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         IDLE, COMMIT: begin
            w_commit = r_wb_valid;
            // A load whose data is not returned in the capture cycle waits.
            if (bus.ex_dm_valid && bus.ex_dm_wb_mux_ctrl && !bus.dm_rvalid)
               w_state_nxt = WAIT_MEM;
            else
               w_state_nxt = IDLE;
         end
         WAIT_MEM: begin
            w_stall = 1'b1;
            if (bus.dm_rvalid)  w_state_nxt = COMMIT;
            else if (w_timeout) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Load data is taken either alongside the op (same-cycle return) or
   // while waiting; a return with nothing pending is ignored.
   assign w_load_latch = bus.dm_rvalid &&
                         ((r_state == WAIT_MEM) ||
                          (bus.ex_dm_valid && bus.ex_dm_wb_mux_ctrl));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_data <= '0;
         r_wait_cnt  <= '0;
         r_retired   <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_load_latch)
            r_load_data <= bus.dm_rdata;
         if (r_state == WAIT_MEM)
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
         else
            r_wait_cnt <= '0;
         if (w_commit)
            r_retired <= r_retired + CNT_W'(1);
         if (w_timeout)
            r_err <= 1'b1;
      end
   end

   assign w_addr_nz = (r_wb_addr != ADDR_W'(REG_ZERO));
   assign w_wd_data = r_wb_mux_ctrl ? r_load_data : r_alu_result;

   assign bus.wb_stall     = w_stall;
   assign wd_addr          = r_wb_addr;
   assign wd_data          = w_wd_data;
   assign rd_w_enable      = w_commit && r_w_enable && w_addr_nz;
   assign dm_wb_inst       = r_wb_valid ? r_inst : 32'd0;
   assign fwd_wb_valid     = r_wb_valid && r_w_enable && w_addr_nz && (r_state != WAIT_MEM);
   assign fwd_wb_addr      = r_wb_addr;
   assign fwd_wb_data      = w_wd_data;
   assign retired_count    = r_retired;
   assign err_mem_timeout  = r_err;
endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_stage                                                |
// | Description : Self-checking bench for wb_stage: vector table for single  |
// |               cycle ops, hand sequences for multi-cycle loads, timeout   |
// |               and reset during a pending load; write scoreboard.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_wb_stage;
   import wb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [4:0]  wd_addr;
   logic [31:0] wd_data;
   logic        rd_w_enable;
   logic [31:0] dm_wb_inst;
   logic        fwd_wb_valid;
   logic [4:0]  fwd_wb_addr;
   logic [31:0] fwd_wb_data;
   logic [31:0] retired_count;
   logic        err_mem_timeout;

   wb_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   wb_stage #(
      .DATA_W      (32),
      .ADDR_W      (5),
      .MEM_TIMEOUT (15),
      .CNT_W       (32)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .wd_addr         (wd_addr),
      .wd_data         (wd_data),
      .rd_w_enable     (rd_w_enable),
      .dm_wb_inst      (dm_wb_inst),
      .fwd_wb_valid    (fwd_wb_valid),
      .fwd_wb_addr     (fwd_wb_addr),
      .fwd_wb_data     (fwd_wb_data),
      .retired_count   (retired_count),
      .err_mem_timeout (err_mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] alu;
      logic [4:0]  addr;
      logic        we;
      logic        mux;
      logic        rvalid;
      logic [31:0] rdata;
      logic        exp_we;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   vec_t vecs[6];
   wr_t  sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic v, input logic [31:0] inst, input logic [31:0] alu,
                           input logic [4:0] addr, input logic we, input logic mux);
      bus.ex_dm_valid       = v;
      bus.ex_dm_inst        = inst;
      bus.ex_dm_alu_result  = alu;
      bus.ex_dm_wb_addr     = addr;
      bus.ex_dm_w_enable    = we;
      bus.ex_dm_wb_mux_ctrl = mux;
   endtask

   task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      sb_q.push_back(w);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"},   bus.wb_stall, 0);
      chk({tag, "_we"},      rd_w_enable, 0);
      chk({tag, "_wd_addr"}, wd_addr, 0);
      chk({tag, "_wd_data"}, wd_data, 0);
      chk({tag, "_inst"},    dm_wb_inst, 0);
      chk({tag, "_fwd_v"},   fwd_wb_valid, 0);
      chk({tag, "_fwd_d"},   fwd_wb_data, 0);
      chk({tag, "_retired"}, retired_count, 0);
      chk({tag, "_err"},     err_mem_timeout, 0);
   endtask

   // Write scoreboard: every register-file write must match the next expected one.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rd_w_enable === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: r%0d <= 0x%0h with none expected", wd_addr, wd_data);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            chk("sb_wr_addr", wd_addr, e.addr);
            chk("sb_wr_data", wd_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stall_n;
      logic [31:0] base;

      //               inst                       alu           addr we mux rv rdata         exp_we exp_data
      vecs[0] = '{32'h0000_0005, 32'h0000_0011, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0011};
      vecs[1] = '{32'h0000_0006, 32'h0000_0022, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0022};
      vecs[2] = '{32'h0000_0007, 32'h0000_0033, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0033};
      vecs[3] = '{{OPC_LW, 26'h8}, 32'h0000_0100, 5'd8, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
      vecs[4] = '{32'h0000_0055, 32'h0000_0055, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0055};
      vecs[5] = '{32'h0000_0303, 32'h0000_0099, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0099};

      rst_n        = 1'b0;
      drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      bus.dm_rvalid = 1'b0;
      bus.dm_rdata  = 32'h0;
      tick(); tick(); tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // ---- single-cycle ops, back to back ----
      for (int i = 0; i < 6; i++) begin
         drive_op(1'b1, vecs[i].inst, vecs[i].alu, vecs[i].addr, vecs[i].we, vecs[i].mux);
         bus.dm_rvalid = vecs[i].rvalid;
         bus.dm_rdata  = vecs[i].rdata;
         if (vecs[i].exp_we) push_wr(vecs[i].addr, vecs[i].exp_data);
         tick();
         bus.dm_rvalid = 1'b0;
         chk("vec_stall",   bus.wb_stall, 0);
         chk("vec_we",      rd_w_enable, vecs[i].exp_we);
         chk("vec_fwd_v",   fwd_wb_valid, vecs[i].exp_we);
         chk("vec_inst",    dm_wb_inst, vecs[i].inst);
         chk("vec_retired", retired_count, i);
         if (vecs[i].exp_we) begin
            chk("vec_wd_addr", wd_addr, vecs[i].addr);
            chk("vec_wd_data", wd_data, vecs[i].exp_data);
            chk("vec_fwd_a",   fwd_wb_addr, vecs[i].addr);
            chk("vec_fwd_d",   fwd_wb_data, vecs[i].exp_data);
         end
      end
      drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      tick();
      chk("idle_inst",    dm_wb_inst, 0);
      chk("idle_retired", retired_count, 6);

      // ---- multi-cycle load: data on the 4th stall cycle, ALU op held ----
      drive_op(1'b1, {OPC_LW, 26'h9}, 32'h0000_0200, 5'd9, 1'b1, 1'b1);
      push_wr(5'd9, 32'hCAFE0001);
      tick();
      drive_op(1'b1, 32'h0000_000A, 32'h0000_0077, 5'd10, 1'b1, 1'b0);
      push_wr(5'd10, 32'h0000_0077);
      for (int k = 1; k <= 4; k++) begin
         chk("ml_stall",  bus.wb_stall, 1);
         chk("ml_we",     rd_w_enable, 0);
         chk("ml_fwd_v",  fwd_wb_valid, 0);
         if (k == 4) begin
            bus.dm_rvalid = 1'b1;
            bus.dm_rdata  = 32'hCAFE0001;
         end
         tick();
      end
      bus.dm_rvalid = 1'b0;
      bus.dm_rdata  = 32'h0;
      chk("ml_commit_stall", bus.wb_stall, 0);
      chk("ml_commit_we",    rd_w_enable, 1);
      chk("ml_commit_addr",  wd_addr, 9);
      chk("ml_commit_data",  wd_data, 32'hCAFE0001);
      tick();
      drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("ml_held_we",   rd_w_enable, 1);
      chk("ml_held_addr", wd_addr, 10);
      chk("ml_held_data", wd_data, 32'h77);
      // Stray read return with nothing pending.
      bus.dm_rvalid = 1'b1;
      bus.dm_rdata  = 32'h1234_5678;
      tick();
      bus.dm_rvalid = 1'b0;
      chk("stray_stall", bus.wb_stall, 0);
      tick();
      chk("stray_we",    rd_w_enable, 0);
      chk("ml_retired",  retired_count, 8);

      // ---- timeout ----
      drive_op(1'b1, {OPC_LW, 26'hB}, 32'h0000_0300, 5'd11, 1'b1, 1'b1);
      tick();
      drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      base    = retired_count;
      stall_n = 0;
      while (bus.wb_stall === 1'b1 && stall_n < 40) begin
         stall_n++;
         tick();
      end
      chk("to_stall_cycles", stall_n, 15);
      chk("to_err",          err_mem_timeout, 1);
      chk("to_we",           rd_w_enable, 0);
      bus.dm_rvalid = 1'b1;
      bus.dm_rdata  = 32'hBADBAD00;
      tick();
      bus.dm_rvalid = 1'b0;
      tick();
      chk("to_err_sticky",  err_mem_timeout, 1);
      chk("to_retired",     retired_count, base);

      // ---- reset while a load is pending ----
      drive_op(1'b1, {OPC_LW, 26'hC}, 32'h0000_0400, 5'd12, 1'b1, 1'b1);
      tick();
      drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      tick(); tick();
      chk("rm_pre_stall", bus.wb_stall, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rm");
      tick();
      rst_n = 1'b1;
      bus.dm_rvalid = 1'b1;
      bus.dm_rdata  = 32'hFEED_F00D;
      tick();
      bus.dm_rvalid = 1'b0;
      chk("rm_post_stall", bus.wb_stall, 0);
      chk("rm_post_we",    rd_w_enable, 0);
      tick();
      chk("rm_post_we2",   rd_w_enable, 0);
      chk("rm_post_ret",   retired_count, 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
